// File: rtl/laser_frame_scheduler.sv
// Shares one LASER two-circle search engine between two requesters: arbitrates a
// 40-target frame, buffers it, replays it to the engine and returns the centres.
module laser_frame_scheduler #(
  parameter int NPTS        = 40,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] REQ_VALID,
  output logic [1:0] REQ_READY,
  input  logic [7:0] REQ_X,
  input  logic [7:0] REQ_Y,
  output logic       ENG_RST,
  output logic [3:0] ENG_X,
  output logic [3:0] ENG_Y,
  input  logic       ENG_DONE,
  input  logic [3:0] ENG_C1X,
  input  logic [3:0] ENG_C1Y,
  input  logic [3:0] ENG_C2X,
  input  logic [3:0] ENG_C2Y,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic       RES_ID,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic       RES_ERR,
  output logic       BUSY
);
  localparam int CW = $clog2(NPTS);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, RESP} state_t;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } tgt_t;

  state_t          state, state_nxt;
  logic            rr_ptr, gnt, gnt_nxt;
  logic [CW-1:0]   cnt, rd_idx;
  logic [15:0]     tcnt;
  tgt_t            frame_buf [NPTS];
  tgt_t            in_tgt;
  logic            beat, last_beat, stream_last, tmo;

  assign gnt_nxt     = (REQ_VALID == 2'b11) ? rr_ptr : REQ_VALID[1];
  assign in_tgt      = gnt ? tgt_t'({REQ_X[7:4], REQ_Y[7:4]}) : tgt_t'({REQ_X[3:0], REQ_Y[3:0]});
  assign beat        = (state == LOAD) && REQ_VALID[gnt];
  assign last_beat   = beat && (cnt == CW'(NPTS-1));
  assign stream_last = (state == STREAM) && (cnt == CW'(NPTS-1));
  assign tmo         = (tcnt == 16'(TIMEOUT_CYC-1));
  assign rd_idx      = cnt + 1'b1;
  assign REQ_READY   = (state == LOAD) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|REQ_VALID)           state_nxt = LOAD;
      LOAD:    if (last_beat)            state_nxt = STREAM;
      STREAM:  if (stream_last)          state_nxt = WAIT;
      WAIT:    if (ENG_DONE || tmo)      state_nxt = RESP;
      RESP:    if (RES_READY)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Frame storage carries no reset; contents are only read after a full load.
  always_ff @(posedge CLK) begin
    if (beat) frame_buf[cnt] <= in_tgt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr    <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      tcnt      <= '0;
      ENG_RST   <= 1'b1;
      ENG_X     <= '0;
      ENG_Y     <= '0;
      RES_VALID <= 1'b0;
      RES_ID    <= 1'b0;
      RES_C1X   <= '0;
      RES_C1Y   <= '0;
      RES_C2X   <= '0;
      RES_C2Y   <= '0;
      RES_ERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ_VALID) begin
            gnt    <= gnt_nxt;
            rr_ptr <= ~gnt_nxt;
          end
        end
        LOAD: begin
          if (beat) cnt <= last_beat ? '0 : cnt + 1'b1;
          // Target 0 must already be on the bus in the first STREAM cycle.
          if (last_beat) begin
            ENG_RST        <= 1'b0;
            {ENG_X, ENG_Y} <= frame_buf[0];
          end
        end
        STREAM: begin
          if (stream_last) begin
            cnt  <= '0;
            tcnt <= '0;
          end else begin
            cnt            <= rd_idx;
            {ENG_X, ENG_Y} <= frame_buf[rd_idx];
          end
        end
        WAIT: begin
          tcnt <= tcnt + 16'd1;
          // The engine clears its centres after DONE, so capture on this edge.
          if (ENG_DONE) begin
            RES_C1X   <= ENG_C1X;
            RES_C1Y   <= ENG_C1Y;
            RES_C2X   <= ENG_C2X;
            RES_C2Y   <= ENG_C2Y;
            RES_ERR   <= 1'b0;
            RES_ID    <= gnt;
            RES_VALID <= 1'b1;
            ENG_RST   <= 1'b1;
          end else if (tmo) begin
            RES_C1X   <= '0;
            RES_C1Y   <= '0;
            RES_C2X   <= '0;
            RES_C2Y   <= '0;
            RES_ERR   <= 1'b1;
            RES_ID    <= gnt;
            RES_VALID <= 1'b1;
            ENG_RST   <= 1'b1;
          end
        end
        RESP: begin
          if (RES_READY) RES_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_frame_scheduler.sv
// Directed job table for laser_frame_scheduler: arbitration, streaming, timeout,
// backpressure, spurious DONE and mid-stream reset.
module tb_laser_frame_scheduler;
  localparam int NPTS = 40;

  logic        CLK, RST_N;
  logic [1:0]  REQ_VALID, REQ_READY;
  logic [7:0]  REQ_X, REQ_Y;
  logic        ENG_RST, ENG_DONE;
  logic [3:0]  ENG_X, ENG_Y;
  logic [15:0] eng_c;
  logic        RES_VALID, RES_READY, RES_ID, RES_ERR, BUSY;
  logic [3:0]  RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;

  laser_frame_scheduler #(.NPTS(NPTS), .TIMEOUT_CYC(200)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_X(REQ_X), .REQ_Y(REQ_Y),
    .ENG_RST(ENG_RST), .ENG_X(ENG_X), .ENG_Y(ENG_Y), .ENG_DONE(ENG_DONE),
    .ENG_C1X(eng_c[15:12]), .ENG_C1Y(eng_c[11:8]), .ENG_C2X(eng_c[7:4]), .ENG_C2Y(eng_c[3:0]),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ID(RES_ID),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .RES_ERR(RES_ERR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [1:0] vmask;
    int         dly;       // WAIT cycle index in which DONE is pulsed, -1 = never
    logic [15:0] c;        // {C1X,C1Y,C2X,C2Y} shown by the engine on DONE
    int         stall_at;
    int         stall_len;
    int         hold;      // cycles RES_READY stays low
    bit         spur;
    int         abort_k;   // stream index at which reset is pulsed, -1 = none
    bit         exp_err;
    int         exp_wait;  // WAIT cycles until RES_VALID is seen
  } job_t;

  job_t       jobs [12];
  int         bi [2];
  logic [1:0] acc;
  int         stall_n;
  int         n_chk, n_fail;

  function automatic logic [3:0] px(input int r, input int i);
    return (r == 0) ? 4'(i) : 4'(15 - i);
  endfunction
  function automatic logic [3:0] py(input int r, input int i);
    return (r == 0) ? 4'(3 * i) : 4'(i + 9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input job_t j);
    logic v;
    for (int r = 0; r < 2; r++) begin
      v = j.vmask[r] && (bi[r] < NPTS);
      if (r == j.id && bi[r] == j.stall_at && stall_n < j.stall_len) begin
        v = 1'b0;
        stall_n++;
      end
      REQ_VALID[r]    = v;
      REQ_X[r*4 +: 4] = px(r, bi[r]);
      REQ_Y[r*4 +: 4] = py(r, bi[r]);
    end
  endtask

  task automatic step();
    acc = REQ_VALID & REQ_READY;
    @(negedge CLK);
    bi[0] += int'(acc[0]);
    bi[1] += int'(acc[1]);
  endtask

  task automatic run_job(input job_t j);
    int          cyc, w, bad;
    logic [15:0] exp_c;
    logic [1:0]  exp_rdy;
    stall_n = 0;
    bad     = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (!ENG_RST) break;
      exp_rdy = BUSY ? (j.id == 1 ? 2'b10 : 2'b01) : 2'b00;
      if (REQ_READY !== exp_rdy || RES_VALID) bad++;
      drive_req(j);
      ENG_DONE = j.spur && (bi[j.id] == 10);
      step();
    end
    ENG_DONE = 1'b0;
    chk("load_bound", 32'(cyc < 3000), 32'd1);
    chk("load_beats", 32'(bi[j.id]), 32'(NPTS));
    chk("load_ready", 32'(bad), 32'd0);
    if (cyc >= 3000) return;

    bad = 0;
    for (int k = 0; k < NPTS; k++) begin
      if (k == j.abort_k) begin
        RST_N = 1'b0;
        #1;
        chk("abort_state", 32'({ENG_RST, RES_VALID, BUSY, REQ_READY, ENG_X, ENG_Y}),
            32'({1'b1, 1'b0, 1'b0, 2'b00, 8'h00}));
        @(negedge CLK);
        RST_N = 1'b1;
        bi[0] = 0;
        bi[1] = 0;
        return;
      end
      if (ENG_RST !== 1'b0 || ENG_X !== px(j.id, k) || ENG_Y !== py(j.id, k) ||
          RES_VALID || REQ_READY !== 2'b00) bad++;
      ENG_DONE = j.spur && (k == 5);
      drive_req(j);
      step();
    end
    ENG_DONE = 1'b0;
    chk("stream_data", 32'(bad), 32'd0);

    bad = 0;
    for (w = 0; w < 1000; w++) begin
      if (RES_VALID) break;
      if (ENG_RST !== 1'b0 || !BUSY || ENG_X !== px(j.id, NPTS-1) || ENG_Y !== py(j.id, NPTS-1)) bad++;
      ENG_DONE = (w == j.dly);
      eng_c    = (w == j.dly) ? j.c : 16'hA5C3;
      drive_req(j);
      step();
    end
    ENG_DONE = 1'b0;
    eng_c    = 16'hA5C3;
    chk("wait_len", 32'(w), 32'(j.exp_wait));
    chk("wait_state", 32'(bad), 32'd0);

    exp_c = j.exp_err ? 16'h0000 : j.c;
    chk("res_id", 32'(RES_ID), 32'(j.id));
    chk("res_centres", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'(exp_c));
    chk("res_err", 32'(RES_ERR), 32'(j.exp_err));
    chk("resp_state", 32'({ENG_RST, BUSY, RES_VALID}), 32'b111);
    bad = 0;
    for (int h = 0; h < j.hold; h++) begin
      RES_READY = 1'b0;
      drive_req(j);
      step();
      if (!RES_VALID || RES_ID !== 1'(j.id) || RES_ERR !== j.exp_err ||
          {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} !== exp_c) bad++;
    end
    chk("res_stable", 32'(bad), 32'd0);
    RES_READY = 1'b1;
    drive_req(j);
    step();
    RES_READY = 1'b0;
    chk("post_accept", 32'({RES_VALID, BUSY}), 32'b00);
    bi[j.id] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    bi[0] = 0; bi[1] = 0;
    RST_N = 1'b0; REQ_VALID = 2'b00; REQ_X = '0; REQ_Y = '0;
    ENG_DONE = 1'b0; eng_c = 16'hA5C3; RES_READY = 1'b0;

    //           id vmask  dly  c        s_at s_len hold spur abort err wait
    jobs[0]  = '{0, 2'b11, 100, 16'h56AB, 0,   0,    0,   0,   -1,   0,  101};
    jobs[1]  = '{1, 2'b11, 20,  16'h1234, 0,   0,    2,   0,   -1,   0,  21};
    jobs[2]  = '{0, 2'b11, 0,   16'hFEDC, 0,   0,    0,   0,   -1,   0,  1};
    jobs[3]  = '{0, 2'b01, 100, 16'h56AB, 0,   0,    0,   0,   -1,   0,  101};
    jobs[4]  = '{0, 2'b01, 50,  16'h789A, 17,  7,    5,   0,   -1,   0,  51};
    jobs[5]  = '{1, 2'b10, -1,  16'h3333, 0,   0,    1,   0,   -1,   1,  200};
    jobs[6]  = '{0, 2'b01, 199, 16'h9876, 0,   0,    0,   0,   -1,   0,  200};
    jobs[7]  = '{1, 2'b10, 200, 16'h2222, 0,   0,    0,   0,   -1,   1,  200};
    jobs[8]  = '{0, 2'b01, 30,  16'h4567, 0,   0,    0,   1,   -1,   0,  31};
    jobs[9]  = '{0, 2'b01, 60,  16'h1111, 0,   0,    0,   0,   20,   0,  61};
    jobs[10] = '{0, 2'b11, 40,  16'hCDEF, 0,   0,    0,   0,   -1,   0,  41};
    jobs[11] = '{1, 2'b11, 10,  16'h0F0F, 0,   0,    3,   0,   -1,   0,  11};

    repeat (3) @(negedge CLK);
    chk("reset_values",
        32'({ENG_RST, ENG_X, ENG_Y, REQ_READY, RES_VALID, RES_ID, RES_C1X, RES_C1Y,
             RES_C2X, RES_C2Y, RES_ERR, BUSY}),
        32'({1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}));
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) run_job(jobs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
